// File: rtl/tpx3_tcp_packer_if.sv
// Arbiter-side and TCP-side handshake signals of the Timepix3 TCP packer.
// The slave modport is the packer's view; the master modport is the driving side.
interface tpx3_tcp_packer_if;
    logic        ARB_WRITE;
    logic [31:0] ARB_DATA;
    logic        ARB_READY;
    logic        TCP_OPEN;
    logic        TCP_TX_FULL;
    logic        TCP_TX_WR;
    logic [7:0]  TCP_TX_DATA;

    modport slave (
        input  ARB_WRITE,
        input  ARB_DATA,
        input  TCP_OPEN,
        input  TCP_TX_FULL,
        output ARB_READY,
        output TCP_TX_WR,
        output TCP_TX_DATA
    );

    modport master (
        output ARB_WRITE,
        output ARB_DATA,
        output TCP_OPEN,
        output TCP_TX_FULL,
        input  ARB_READY,
        input  TCP_TX_WR,
        input  TCP_TX_DATA
    );
endinterface

// File: rtl/tpx3_tcp_packer.sv
// Buffers 32-bit arbiter words in a FIFO and streams them LSB byte first
// into a TCP transmit buffer, one byte per cycle when the buffer has room.
module tpx3_tcp_packer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST_N,
    tpx3_tcp_packer_if.slave  bus,
    input  logic              CLR_ERR,
    output logic [LW-1:0]     FIFO_LEVEL,
    output logic              OVERFLOW,
    output logic [31:0]       WORD_CNT
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StB0, StB1, StB2, StB3} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     word_q, word_d;
    logic            tx_wr_q, tx_wr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            ready_q, ready_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            init_q;
    logic            fifo_full, fifo_empty;
    logic            pop, push, drop;

    assign fifo_full  = (level_q == LW'(DEPTH));
    assign fifo_empty = (level_q == '0);

    // Serializer: the word register is loaded on pop and bytes are picked by state.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        if (!bus.TCP_OPEN) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        word_d  = mem_q[rd_ptr_q];
                        state_d = StB0;
                    end
                end
                StB0: begin
                    if (!bus.TCP_TX_FULL) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = word_q[7:0];
                        state_d   = StB1;
                    end
                end
                StB1: begin
                    if (!bus.TCP_TX_FULL) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = word_q[15:8];
                        state_d   = StB2;
                    end
                end
                StB2: begin
                    if (!bus.TCP_TX_FULL) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = word_q[23:16];
                        state_d   = StB3;
                    end
                end
                StB3: begin
                    if (!bus.TCP_TX_FULL) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = word_q[31:24];
                        cnt_d     = cnt_q + 32'd1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            word_d  = mem_q[rd_ptr_q];
                            state_d = StB0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A full FIFO still accepts a word when the serializer pops in the same cycle.
    always_comb begin
        push     = bus.ARB_WRITE && bus.TCP_OPEN && (!fifo_full || pop);
        drop     = bus.ARB_WRITE && bus.TCP_OPEN && fifo_full && !pop;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (!bus.TCP_OPEN) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        ready_d = bus.TCP_OPEN && init_q && (level_d <= LW'(DEPTH - 2));
        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_ERR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.ARB_DATA;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            word_q    <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            word_q    <= word_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            // Holds ARB_READY low for the first edge after reset release.
            init_q    <= 1'b1;
        end
    end

    assign bus.ARB_READY   = ready_q;
    assign bus.TCP_TX_WR   = tx_wr_q;
    assign bus.TCP_TX_DATA = tx_data_q;
    assign FIFO_LEVEL      = level_q;
    assign OVERFLOW        = ovf_q;
    assign WORD_CNT        = cnt_q;

endmodule

// File: tb/tb_tpx3_tcp_packer.sv
// Scoreboard bench for tpx3_tcp_packer: expected bytes are queued at stimulus time
// and a negedge monitor compares every TCP_TX_WR byte against the queue head.
module tb_tpx3_tcp_packer;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_err;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [31:0]   word_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    tpx3_tcp_packer_if bus ();

    tpx3_tcp_packer #(.DEPTH(DEPTH)) dut (
        .BUS_CLK    (clk),
        .BUS_RST_N  (rst_n),
        .bus        (bus),
        .CLR_ERR    (clr_err),
        .FIFO_LEVEL (fifo_level),
        .OVERFLOW   (overflow),
        .WORD_CNT   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every byte written to the TCP buffer must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.TCP_TX_WR === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got 0x%02h expected no write at %0t",
                         bus.TCP_TX_DATA, $time);
            end else begin
                check("tx_byte", 32'(bus.TCP_TX_DATA), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w, input int nbytes);
        for (int b = 0; b < nbytes; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic arb_write(input logic [31:0] w);
        bus.ARB_WRITE = 1'b1;
        bus.ARB_DATA  = w;
        tick();
        bus.ARB_WRITE = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        push_exp(w, 4);
        arb_write(w);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        tick();
        check("ready_edge1", 32'(bus.ARB_READY), 32'd0);
        tick();
        check("ready_edge2", 32'(bus.ARB_READY), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr"},    32'(bus.TCP_TX_WR),   32'd0);
        check({tag, "_data"},  32'(bus.TCP_TX_DATA), 32'd0);
        check({tag, "_ready"}, 32'(bus.ARB_READY),   32'd0);
        check({tag, "_level"}, 32'(fifo_level),      32'd0);
        check({tag, "_ovf"},   32'(overflow),        32'd0);
        check({tag, "_cnt"},   word_cnt,             32'd0);
    endtask

    initial begin
        int lvl;
        bit seen;
        rst_n           = 1'b0;
        clr_err         = 1'b0;
        bus.ARB_WRITE   = 1'b0;
        bus.ARB_DATA    = '0;
        bus.TCP_OPEN    = 1'b1;
        bus.TCP_TX_FULL = 1'b0;
        #2;
        check_reset_values("rst");
        repeat (2) tick();
        release_reset();

        // Single word: bytes 44,33,22,11, first write two cycles after the push edge.
        write_word(32'h1122_3344);
        @(negedge clk); check("lat_edge1", 32'(bus.TCP_TX_WR), 32'd0);
        @(negedge clk); check("lat_edge2", 32'(bus.TCP_TX_WR), 32'd0);
        @(negedge clk); check("lat_edge3", 32'(bus.TCP_TX_WR), 32'd1);
        drain(20);
        check("cnt_single", word_cnt, 32'd1);

        // Back-to-back words must produce eight contiguous byte writes.
        write_word(32'hA0A1_A2A3);
        write_word(32'hB0B1_B2B3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.TCP_TX_WR;
        end
        check("contig_start", 32'(seen), 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("contig_run", 32'(bus.TCP_TX_WR), 32'd1);
        end
        drain(20);
        check("cnt_b2b", word_cnt, 32'd3);

        // Three-cycle stall while in B1: byte 1 resent once the buffer frees up.
        write_word(32'h5566_7788);
        tick();
        tick();
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_wr", 32'(bus.TCP_TX_WR), 32'd0);
            check("stall_data", 32'(bus.TCP_TX_DATA), 32'h88);
        end
        bus.TCP_TX_FULL = 1'b0;
        drain(20);
        check("cnt_stall", word_cnt, 32'd4);

        // Overflow: DEPTH+2 forced writes with the TCP buffer blocked.
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 1; i <= DEPTH + 2; i++) begin
            if (i <= DEPTH + 1) push_exp(32'hC0DE_0000 | 32'(i), 4);
            arb_write(32'hC0DE_0000 | 32'(i));
            lvl = (i == 1) ? 1 : ((i - 1 > DEPTH) ? DEPTH : i - 1);
            check("ovf_level", 32'(fifo_level), 32'(lvl));
            check("ovf_ready", 32'(bus.ARB_READY), 32'(lvl <= DEPTH - 2));
            check("ovf_flag", 32'(overflow), 32'(i == DEPTH + 2));
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        bus.TCP_TX_FULL = 1'b0;
        drain(200);
        check("cnt_ovf", word_cnt, 32'd21);

        // Connection drop in B2 with three words queued.
        push_exp(32'h0403_0201, 2);
        arb_write(32'h0403_0201);
        arb_write(32'h1413_1211);
        arb_write(32'h2423_2221);
        arb_write(32'h3433_3231);
        check("close_level_pre", 32'(fifo_level), 32'd3);
        bus.TCP_OPEN = 1'b0;
        tick();
        check("close_level", 32'(fifo_level), 32'd0);
        check("close_wr", 32'(bus.TCP_TX_WR), 32'd0);
        check("close_ready", 32'(bus.ARB_READY), 32'd0);
        check("close_cnt", word_cnt, 32'd21);
        check("close_ovf", 32'(overflow), 32'd0);
        arb_write(32'hDEAD_0001);
        arb_write(32'hDEAD_0002);
        tick();
        check("closed_wr_level", 32'(fifo_level), 32'd0);
        check("closed_wr_ovf", 32'(overflow), 32'd0);
        check("closed_queue", 32'(exp_q.size()), 32'd0);
        bus.TCP_OPEN = 1'b1;
        repeat (2) tick();
        check("reopen_ready", 32'(bus.ARB_READY), 32'd1);

        // Reset mid-B1: the word is discarded and nothing more is written.
        arb_write(32'hDEAD_BEEF);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) tick();
        release_reset();
        write_word(32'h0A0B_0C0D);
        drain(20);
        check("cnt_after_rst", word_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tpx3_tcp_packer.md
TPX3_TCP_PACKER -- requirements
Module: tpx3_tcp_packer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit words, power of two, minimum 4.
REQ-002 Parameter LW, default $clog2(DEPTH)+1, width of FIFO_LEVEL.
REQ-003 BUS_CLK  in  1  sole clock, all logic on rising edge.
REQ-004 BUS_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 ARB_WRITE  in  1  arbiter write strobe, one word per high cycle.
REQ-006 ARB_DATA  in  32  arbiter data word.
REQ-007 ARB_READY  out  1  packer can accept arbiter words.
REQ-008 TCP_OPEN  in  1  TCP connection established.
REQ-009 TCP_TX_FULL  in  1  TCP transmit buffer full, no byte write allowed.
REQ-010 TCP_TX_WR  out  1  byte write strobe to TCP transmit buffer.
REQ-011 TCP_TX_DATA  out  8  byte to TCP transmit buffer.
REQ-012 CLR_ERR  in  1  clears OVERFLOW.
REQ-013 FIFO_LEVEL  out  LW  words currently stored.
REQ-014 OVERFLOW  out  1  sticky, a word was dropped.
REQ-015 WORD_CNT  out  32  words fully transmitted.

Function
REQ-016 Word FIFO of DEPTH entries; push when ARB_WRITE=1 and level<DEPTH; pop when the serializer loads a word.
REQ-017 Push and pop in the same cycle leave FIFO_LEVEL unchanged; FIFO_LEVEL is registered and updates one edge after the push/pop.
REQ-018 ARB_WRITE=1 with level=DEPTH and no same-cycle pop drops the word and sets OVERFLOW at the next edge.
REQ-019 ARB_READY is registered: high when TCP_OPEN=1 and next level <= DEPTH-2; one word of slack covers the registered-ready latency.
REQ-020 Serializer FSM states IDLE, B0, B1, B2, B3.
REQ-021 IDLE: if TCP_OPEN=1 and FIFO non-empty, pop head into 32-bit shift register, go to B0.
REQ-022 Bn (n=0..3): if TCP_TX_FULL=0, drive TCP_TX_WR=1 and TCP_TX_DATA=word[8n+7:8n] at the next edge, then advance; LSB byte first.
REQ-023 Bn with TCP_TX_FULL=1: hold state, TCP_TX_WR=0 at the next edge, TCP_TX_DATA unchanged.
REQ-024 B3 byte sent: increment WORD_CNT (wraps 0xFFFFFFFF->0). If the FIFO is non-empty and TCP_OPEN=1, pop and go to B0 directly; otherwise go to IDLE.
REQ-025 Sustained throughput: one byte per cycle when TCP_TX_FULL=0 and the FIFO stays non-empty.
REQ-026 TCP_TX_WR and TCP_TX_DATA are registered; TCP_TX_WR is never high in IDLE.
REQ-027 Latency: word pushed at edge k into an empty FIFO with the FSM in IDLE gives the first TCP_TX_WR high in the cycle after edge k+2.
REQ-028 TCP_OPEN falling, any state:
- next edge: FSM to IDLE, partial word discarded (WORD_CNT not incremented), FIFO flushed to level 0, TCP_TX_WR=0, ARB_READY=0.
- arbiter writes are dropped while TCP_OPEN=0 without setting OVERFLOW.
REQ-029 CLR_ERR=1 clears OVERFLOW at the next edge; a simultaneous drop event takes priority and OVERFLOW stays 1.

Reset
REQ-030 BUS_RST_N=0 immediately forces FSM=IDLE, FIFO_LEVEL=0, pointers=0, ARB_READY=0, TCP_TX_WR=0, TCP_TX_DATA=0x00, OVERFLOW=0, WORD_CNT=0.
REQ-031 Reset release is taken synchronously. ARB_READY rises no earlier than the second edge after release with TCP_OPEN=1.
REQ-032 Reset asserted mid-word discards the word; no TCP_TX_WR after assertion.

Verification
REQ-033 TCP_OPEN=1, TCP_TX_FULL=0, one write 0x11223344 -> 4 consecutive TCP_TX_WR bytes 44,33,22,11; first byte 2 cycles after write; WORD_CNT=1.
REQ-034 Back-to-back writes 0xA0A1A2A3, 0xB0B1B2B3 -> 8 contiguous TCP_TX_WR cycles with no gap, order A3..A0, B3..B0; WORD_CNT=2.
REQ-035 TCP_TX_FULL=1 for 3 cycles while in B1 -> TCP_TX_WR low for 3 cycles, byte 1 resent unchanged afterwards, no byte lost or duplicated.
REQ-036 TCP_TX_FULL=1 held, DEPTH+2 writes forced ignoring ARB_READY -> ARB_READY low at level DEPTH-1, FIFO_LEVEL=DEPTH, OVERFLOW=1; CLR_ERR pulse -> OVERFLOW=0.
REQ-037 TCP_OPEN dropped while in B2 with 3 words queued -> FIFO_LEVEL=0 next cycle, no further TCP_TX_WR, WORD_CNT unchanged, OVERFLOW=0.
REQ-038 BUS_RST_N pulsed low mid-B1 -> all outputs at reset values immediately; the next word after release is transmitted from B0.
